// File: rtl/uart_tx_core_if.sv
// Signal bundle between the CPU write side and uart_tx_core.
// Carries the write port, the frame configuration, the serial line and the FIFO status.
interface uart_tx_core_if #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        bd_rate;
    logic [3:0]        d_bits;
    logic              s_num;
    logic [1:0]        par;
    logic              send_break;
    logic              TxD;
    logic              full;
    logic              empty;
    logic [FIFO_AW:0]  level;
    logic              tx_rdy;
    logic              tx_busy;
    logic              wr_overflow;

    modport master (
        output wr_en, wr_data, bd_rate, d_bits, s_num, par, send_break,
        input  TxD, full, empty, level, tx_rdy, tx_busy, wr_overflow
    );

    modport slave (
        input  wr_en, wr_data, bd_rate, d_bits, s_num, par, send_break,
        output TxD, full, empty, level, tx_rdy, tx_busy, wr_overflow
    );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: show-ahead TX FIFO, baud divider and frame serialiser with break support.
// Frame configuration is captured when a word leaves the FIFO, so it stays fixed for that frame.
module uart_tx_core #(
    parameter int CLK_HZ  = 50000000,
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic          clk_50mhz,
    input  logic          n_rst,
    uart_tx_core_if.slave bus
);
    localparam int DEPTH      = 1 << FIFO_AW;
    localparam int DIV_9600   = (CLK_HZ + 4800) / 9600;
    localparam int DIV_19200  = (CLK_HZ + 9600) / 19200;
    localparam int DIV_57600  = (CLK_HZ + 28800) / 57600;
    localparam int DIV_115200 = (CLK_HZ + 57600) / 115200;
    localparam int CNT_W      = $clog2(DIV_9600 + 1);
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [3:0]       MAX_BITS   = 4'(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               overflow_q;
    logic               full, empty, push, pop;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, divisor;
    logic [3:0]         bitIdx_q, bitIdx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [3:0]         nBits_q, nBits_d;
    logic               hasPar_q, hasPar_d;
    logic               parBit_q, parBit_d;
    logic               twoStop_q, twoStop_d;
    logic [1:0]         rate_q, rate_d;
    logic               stop2_q, stop2_d;
    logic               mark_q, mark_d;
    logic               txd_q, txd_d;
    logic [3:0]         effBits;
    logic               headParity;
    logic               bitDone;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign push  = bus.wr_en && !full;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_50mhz) begin
        if (push)
            mem_q[wrPtr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk_50mhz or negedge n_rst) begin
        if (!n_rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)
                rdPtr_q <= rdPtr_q + 1'b1;
            level_q    <= level_d;
            overflow_q <= bus.wr_en && full;
        end
    end

    // Parity of the head word over only the bits that will actually be sent.
    always_comb begin
        effBits = MAX_BITS;
        if (bus.d_bits >= 4'd5 && bus.d_bits <= MAX_BITS)
            effBits = bus.d_bits;
        headParity = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (i < int'(effBits))
                headParity = headParity ^ mem_q[rdPtr_q][i];
        if (bus.par == 2'b01)
            headParity = ~headParity;
    end

    always_comb begin
        case (rate_q)
            2'b00:   divisor = CNT_W'(DIV_9600);
            2'b01:   divisor = CNT_W'(DIV_19200);
            2'b10:   divisor = CNT_W'(DIV_57600);
            default: divisor = CNT_W'(DIV_115200);
        endcase
    end

    assign bitDone = (cnt_q == divisor - 1'b1);

    // Next-state logic; txd_d is the line level for the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        nBits_d   = nBits_q;
        hasPar_d  = hasPar_q;
        parBit_d  = parBit_q;
        twoStop_d = twoStop_q;
        rate_d    = rate_q;
        stop2_d   = stop2_q;
        mark_d    = mark_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                txd_d     = 1'b1;
                rate_d    = bus.bd_rate;
                nBits_d   = effBits;
                hasPar_d  = (bus.par == 2'b01) || (bus.par == 2'b10);
                parBit_d  = headParity;
                twoStop_d = bus.s_num;
                if (bus.send_break) begin
                    state_d = BREAK;
                    mark_d  = 1'b0;
                    txd_d   = 1'b0;
                end else if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rdPtr_q];
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bitDone) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    txd_d    = shift_q[0];
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    cnt_d = '0;
                    if (bitIdx_q == nBits_q - 4'd1) begin
                        if (hasPar_q) begin
                            state_d = PARITY;
                            txd_d   = parBit_q;
                        end else begin
                            state_d = STOP;
                            stop2_d = 1'b0;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                        shift_d  = shift_q >> 1;
                        txd_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bitDone) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    stop2_d = 1'b0;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (bitDone) begin
                    cnt_d = '0;
                    if (twoStop_q && !stop2_q)
                        stop2_d = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            BREAK: begin
                if (!mark_q) begin
                    cnt_d = '0;
                    if (!bus.send_break) begin
                        mark_d = 1'b1;
                        txd_d  = 1'b1;
                    end
                end else if (bitDone) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            nBits_q   <= MAX_BITS;
            hasPar_q  <= 1'b0;
            parBit_q  <= 1'b0;
            twoStop_q <= 1'b0;
            rate_q    <= 2'b00;
            stop2_q   <= 1'b0;
            mark_q    <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            nBits_q   <= nBits_d;
            hasPar_q  <= hasPar_d;
            parBit_q  <= parBit_d;
            twoStop_q <= twoStop_d;
            rate_q    <= rate_d;
            stop2_q   <= stop2_d;
            mark_q    <= mark_d;
            txd_q     <= txd_d;
        end
    end

    assign bus.TxD         = txd_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.level       = level_q;
    assign bus.tx_rdy      = !full;
    assign bus.tx_busy     = (state_q != IDLE);
    assign bus.wr_overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed and random frames checked against a bit-list model.
// A 10 MHz CLK_HZ keeps frame lengths short while the divisor arithmetic stays the same.
module tb_uart_tx_core;
    localparam int CLK_HZ  = 10000000;
    localparam int DATA_W  = 8;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic clk_50mhz = 1'b0;
    logic n_rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   expBits[$];

    uart_tx_core_if #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) bus ();

    uart_tx_core #(.CLK_HZ(CLK_HZ), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
        .clk_50mhz(clk_50mhz),
        .n_rst    (n_rst),
        .bus      (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data);
        bus.wr_data = data;
        bus.wr_en   = 1'b1;
        @(negedge clk_50mhz);
        bus.wr_en   = 1'b0;
    endtask

    function automatic int divOf(input logic [1:0] rate);
        int baud;
        case (rate)
            2'b00:   baud = 9600;
            2'b01:   baud = 19200;
            2'b10:   baud = 57600;
            default: baud = 115200;
        endcase
        return (CLK_HZ + baud / 2) / baud;
    endfunction

    function automatic int nbEff(input int d);
        return (d >= 5 && d <= DATA_W) ? d : DATA_W;
    endfunction

    // Expected line levels, one entry per bit time: start, data LSB first, parity, stop(s).
    task automatic buildFrame(input logic [DATA_W-1:0] word, input int nb, input int parSel, input int stops);
        int ones;
        ones = 0;
        expBits.delete();
        expBits.push_back(0);
        for (int i = 0; i < nb; i++) begin
            expBits.push_back(int'(word[i]));
            ones += int'(word[i]);
        end
        if (parSel == 1)
            expBits.push_back((ones % 2 == 0) ? 1 : 0);
        else if (parSel == 2)
            expBits.push_back(ones % 2);
        for (int i = 0; i < stops; i++)
            expBits.push_back(1);
    endtask

    task automatic waitStart(input int limit, output int waited);
        waited = 0;
        while (bus.TxD !== 1'b0 && waited <= limit) begin
            @(negedge clk_50mhz);
            waited++;
        end
    endtask

    // Called on the first cycle of the start bit; checks first and last cycle of every bit.
    task automatic checkFrame(input string tag, input int div, input bit idleAfter);
        int total;
        total = expBits.size() * div;
        for (int i = 0; i < total; i++) begin
            if (i % div == 0 || i % div == div - 1)
                checkOutput($sformatf("%s_bit%0d_cyc%0d", tag, i / div, i % div), bus.TxD, expBits[i / div]);
            if (i == 0 || i == total - 1)
                checkOutput({tag, "_busy"}, bus.tx_busy, 1);
            @(negedge clk_50mhz);
        end
        if (idleAfter)
            checkOutput({tag, "_idle"}, bus.tx_busy, 0);
    endtask

    initial begin
        int                waited;
        int                div;
        int                zeros;
        int                ps;
        int                ss;
        logic [1:0]        rate;
        logic [3:0]        db;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] words[$];

        bus.wr_en      = 1'b0;
        bus.wr_data    = '0;
        bus.bd_rate    = 2'b11;
        bus.d_bits     = 4'd8;
        bus.s_num      = 1'b0;
        bus.par        = 2'b00;
        bus.send_break = 1'b0;
        n_rst          = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        checkOutput("rst_txd", bus.TxD, 1);
        checkOutput("rst_full", bus.full, 0);
        checkOutput("rst_empty", bus.empty, 1);
        checkOutput("rst_level", bus.level, 0);
        checkOutput("rst_tx_rdy", bus.tx_rdy, 1);
        checkOutput("rst_busy", bus.tx_busy, 0);
        checkOutput("rst_ovf", bus.wr_overflow, 0);
        n_rst = 1'b1;
        @(negedge clk_50mhz);

        // 8N1 at 115200, word 0x55
        div = divOf(2'b11);
        applyStimulus(8'h55);
        checkOutput("t1_empty", bus.empty, 0);
        checkOutput("t1_level", bus.level, 1);
        waitStart(10, waited);
        checkOutput("t1_latency", waited, 1);
        buildFrame(8'h55, 8, 0, 1);
        checkFrame("t1", div, 1'b1);

        // 7 bits odd parity, then a config change mid-frame for the queued word
        bus.d_bits = 4'd7;
        bus.par    = 2'b01;
        w          = 8'($urandom);
        applyStimulus(8'h83);
        applyStimulus(w);
        checkOutput("t2_level", bus.level, 1);
        waitStart(10, waited);
        checkOutput("t2_latency", waited, 0);
        bus.par    = 2'b10;
        bus.d_bits = 4'd5;
        buildFrame(8'h83, 7, 1, 1);
        checkFrame("t2a", div, 1'b0);
        waitStart(10, waited);
        checkOutput("t2_gap", waited, 1);
        buildFrame(w, 5, 2, 1);
        checkFrame("t2b", div, 1'b1);

        // Random configurations including out-of-range d_bits and par=11
        for (int k = 0; k < 4; k++) begin
            rate           = 2'($urandom_range(3, 2));
            db             = 4'($urandom_range(9, 4));
            ps             = int'($urandom_range(3, 0));
            ss             = int'($urandom_range(1, 0));
            w              = 8'($urandom);
            bus.bd_rate    = rate;
            bus.d_bits     = db;
            bus.par        = 2'(ps);
            bus.s_num      = 1'(ss);
            applyStimulus(w);
            waitStart(10, waited);
            checkOutput($sformatf("rnd%0d_latency", k), waited, 1);
            buildFrame(w, nbEff(int'(db)), ps, ss + 1);
            checkFrame($sformatf("rnd%0d", k), divOf(rate), 1'b1);
        end

        // Fill the FIFO while break holds the line, overflow on the 17th write
        bus.bd_rate    = 2'b11;
        bus.d_bits     = 4'd8;
        bus.par        = 2'b00;
        bus.s_num      = 1'b0;
        div            = divOf(2'b11);
        bus.send_break = 1'b1;
        @(negedge clk_50mhz);
        checkOutput("t3_break_txd", bus.TxD, 0);
        checkOutput("t3_break_busy", bus.tx_busy, 1);
        for (int k = 0; k < DEPTH; k++) begin
            w = 8'($urandom);
            words.push_back(w);
            applyStimulus(w);
        end
        checkOutput("t3_level_full", bus.level, DEPTH);
        checkOutput("t3_full", bus.full, 1);
        checkOutput("t3_tx_rdy", bus.tx_rdy, 0);
        checkOutput("t3_no_ovf", bus.wr_overflow, 0);
        applyStimulus(8'($urandom));
        checkOutput("t3_ovf_pulse", bus.wr_overflow, 1);
        checkOutput("t3_ovf_level", bus.level, DEPTH);
        @(negedge clk_50mhz);
        checkOutput("t3_ovf_clear", bus.wr_overflow, 0);
        checkOutput("t3_still_break", bus.TxD, 0);
        bus.send_break = 1'b0;
        @(negedge clk_50mhz);
        checkOutput("t3_mark", bus.TxD, 1);
        waitStart(div + 10, waited);
        checkOutput("t3_mark_len", waited, div + 1);
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0) begin
                waitStart(10, waited);
                checkOutput($sformatf("t3_gap%0d", k), waited, 1);
            end
            checkOutput($sformatf("t3_level%0d", k), bus.level, DEPTH - 1 - k);
            if (k == DEPTH - 1)
                checkOutput("t3_empty_last", bus.empty, 1);
            buildFrame(words[k], 8, 0, 1);
            checkFrame($sformatf("t3f%0d", k), div, k == DEPTH - 1);
        end

        // Write into a full FIFO on the pop cycle, then reset mid-DATA
        bus.send_break = 1'b1;
        @(negedge clk_50mhz);
        for (int k = 0; k < DEPTH; k++)
            applyStimulus(8'h00);
        bus.send_break = 1'b0;
        @(negedge clk_50mhz);
        repeat (div) @(negedge clk_50mhz);
        checkOutput("t4_full_before", bus.full, 1);
        applyStimulus(8'hA5);
        checkOutput("t4_ovf", bus.wr_overflow, 1);
        checkOutput("t4_level", bus.level, DEPTH - 1);
        checkOutput("t4_not_full", bus.full, 0);
        checkOutput("t4_start", bus.TxD, 0);
        repeat (div + div / 2) @(negedge clk_50mhz);
        checkOutput("t4_pre_rst_txd", bus.TxD, 0);
        #3 n_rst = 1'b0;
        #1;
        checkOutput("t4_rst_txd", bus.TxD, 1);
        checkOutput("t4_rst_level", bus.level, 0);
        checkOutput("t4_rst_empty", bus.empty, 1);
        checkOutput("t4_rst_busy", bus.tx_busy, 0);
        @(negedge clk_50mhz);
        n_rst = 1'b1;
        zeros = 0;
        for (int i = 0; i < 3 * 10 * div; i++) begin
            @(negedge clk_50mhz);
            if (bus.TxD !== 1'b1)
                zeros++;
        end
        checkOutput("t4_silent", zeros, 0);
        checkOutput("t4_after_empty", bus.empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
